// File: rtl/uart_tx_sequencer_if.sv
// Host-side byte handshake for the UART transmit sequencer.
interface uart_tx_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: frames host bytes as start/data/stop bits on tx.
// The divisor is captured once per frame at byte acceptance.
module uart_tx_sequencer #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int MIN_DIV   = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [7:0]                 divisor,
  uart_tx_sequencer_if.slave         host,
  output logic                       tx,
  output logic                       busy,
  output logic                       done,
  output logic                       div_wr_ok
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t     state_r, state_s;
  logic [7:0] shift_r, shift_s;
  logic [7:0] period_r, period_s;
  logic [7:0] cnt_r, cnt_s;
  logic [2:0] bit_r, bit_s;
  logic       stop_r, stop_s;
  logic       tx_r, tx_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic       xfer_s;
  logic       tick_s;

  function automatic logic [7:0] clamp_div(input logic [7:0] d);
    if (d < 8'(MIN_DIV)) begin
      return 8'(MIN_DIV);
    end else begin
      return d;
    end
  endfunction

  // Handshake and divisor-write permission are gated by reset so both read 0 while it is held
  assign host.in_ready = (state_r == IDLE) & enable & ~reset;
  assign div_wr_ok     = (state_r == IDLE) & ~enable & ~reset;
  assign xfer_s        = host.in_valid & host.in_ready;
  assign tick_s        = (cnt_r == (period_r - 8'd1));

  // Next-state, counters, and next values of the registered line outputs
  always_comb begin
    state_s  = state_r;
    shift_s  = shift_r;
    period_s = period_r;
    cnt_s    = cnt_r;
    bit_s    = bit_r;
    stop_s   = stop_r;
    tx_s     = 1'b1;
    busy_s   = 1'b0;
    done_s   = 1'b0;

    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          shift_s  = host.in_data;
          period_s = clamp_div(divisor);
          cnt_s    = 8'd0;
          bit_s    = 3'd0;
          state_s  = START;
        end else begin
          state_s  = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          cnt_s   = 8'd0;
          state_s = DATA;
        end else begin
          cnt_s   = cnt_r + 8'd1;
        end
      end
      DATA: begin
        if (tick_s) begin
          cnt_s   = 8'd0;
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'(DATA_BITS - 1)) begin
            stop_s  = 1'b0;
            state_s = STOP;
          end else begin
            bit_s   = bit_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      STOP: begin
        if (tick_s) begin
          cnt_s = 8'd0;
          if (stop_r == 1'(STOP_BITS - 1)) begin
            state_s = IDLE;
          end else begin
            stop_s  = stop_r + 1'b1;
          end
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Outputs are registered, so derive them from where the FSM is heading
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      default: tx_s = 1'b1;
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == STOP) && (cnt_s == (period_s - 8'd1)) &&
             (stop_s == 1'(STOP_BITS - 1));
  end

  // State and output registers; reset abandons any frame in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      shift_r  <= 8'd0;
      period_r <= 8'd0;
      cnt_r    <= 8'd0;
      bit_r    <= 3'd0;
      stop_r   <= 1'b0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      shift_r  <= shift_s;
      period_r <= period_s;
      cnt_r    <= cnt_s;
      bit_r    <= bit_s;
      stop_r   <= stop_s;
      tx_r     <= tx_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign tx   = tx_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: accepted bytes queue expected frames,
// a negedge monitor checks the line cycle by cycle against a waveform model.
module tb_uart_tx_sequencer;

  localparam int NBITS = 1 + 8 + 1;

  typedef struct {
    logic [7:0] data;
    int         period;
    int         start;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] divisor;
  logic       tx, busy, done, div_wr_ok;

  uart_tx_sequencer_if host_if();

  uart_tx_sequencer #(.DATA_BITS(8), .STOP_BITS(1), .MIN_DIV(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .divisor   (divisor),
    .host      (host_if),
    .tx        (tx),
    .busy      (busy),
    .done      (done),
    .div_wr_ok (div_wr_ok)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   free_cycle = 0;
  int   last_start = 0;
  bit   mon_en = 1'b0;
  bit   in_frame = 1'b0;
  exp_t sb[$];
  exp_t cur;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_period(input int d);
    return (d < 5) ? 5 : d;
  endfunction

  // Monitor: expected line level is the frame bit index = elapsed cycles / period
  always begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (!in_frame && sb.size() > 0 && cyc == sb[0].start) begin
        cur = sb.pop_front();
        in_frame = 1'b1;
      end
      if (in_frame) begin
        int k, bi, flen;
        logic etx;
        k    = cyc - cur.start;
        flen = NBITS * cur.period;
        bi   = k / cur.period;
        if (bi == 0) etx = 1'b0;
        else if (bi <= 8) etx = cur.data[bi-1];
        else etx = 1'b1;
        chk("tx", 32'(tx), 32'(etx));
        chk("busy", 32'(busy), 32'd1);
        chk("done", 32'(done), 32'(k == flen - 1));
        chk("in_ready_busy", 32'(host_if.in_ready), 32'd0);
        chk("div_wr_ok_busy", 32'(div_wr_ok), 32'd0);
        if (k == flen - 1) in_frame = 1'b0;
      end else begin
        chk("tx_idle", 32'(tx), 32'd1);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("done_idle", 32'(done), 32'd0);
        chk("in_ready_idle", 32'(host_if.in_ready), 32'(enable));
        chk("div_wr_ok_idle", 32'(div_wr_ok), 32'(!enable));
      end
    end
  end

  // Offer a byte; while the model says busy, in_data carries junk that must be ignored
  task automatic send(input logic [7:0] b, input bit hold);
    int n;
    n = 0;
    host_if.in_valid = 1'b1;
    forever begin
      host_if.in_data = (cyc >= free_cycle) ? b : 8'($urandom);
      #1;
      if (host_if.in_ready) begin
        sb.push_back('{data: b, period: model_period(int'(divisor)), start: cyc + 1});
        last_start = cyc + 1;
        free_cycle = cyc + 1 + NBITS * model_period(int'(divisor));
        @(negedge clk);
        break;
      end
      n = n + 1;
      if (n > 4000) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL send_timeout: byte %0h never accepted", b);
        break;
      end
      @(negedge clk);
    end
    if (!hold) host_if.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cyc < free_cycle + 1 && n < 5000) begin
      @(negedge clk);
      n = n + 1;
    end
  endtask

  task automatic wait_cycle(input int c);
    int n;
    n = 0;
    while (cyc < c && n < 5000) begin
      @(negedge clk);
      n = n + 1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    divisor = 8'd5;
    host_if.in_valid = 1'b0;
    host_if.in_data = 8'd0;
    #3;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(host_if.in_ready), 32'd0);
    chk("rst_div_wr_ok", 32'(div_wr_ok), 32'd0);
    enable = 1'b1;
    #1;
    chk("rst_in_ready_en", 32'(host_if.in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Basic frame, then clamped divisors
    divisor = 8'd5;  send(8'h55, 1'b0); wait_idle();
    divisor = 8'd2;  send(8'h00, 1'b0); wait_idle();
    divisor = 8'd0;  send(8'hFF, 1'b0); wait_idle();

    // Divisor change mid-frame must not stretch bits
    divisor = 8'd10; send(8'hA3, 1'b0);
    wait_cycle(last_start + 50);
    divisor = 8'd20;
    wait_idle();

    // Back-to-back with in_valid held across frames
    divisor = 8'd6;
    send(8'hF0, 1'b1);
    send(8'h0F, 1'b0);
    wait_idle();

    // Drop enable mid-frame; later in_valid with enable low must not transfer
    divisor = 8'd7;
    send(8'h81, 1'b0);
    wait_cycle(last_start + 21);
    enable = 1'b0;
    wait_idle();
    host_if.in_valid = 1'b1;
    host_if.in_data = 8'h81;
    repeat (8) @(negedge clk);
    host_if.in_valid = 1'b0;
    enable = 1'b1;
    @(negedge clk);

    // Longest period
    divisor = 8'd255; send(8'h96, 1'b0); wait_idle();

    // Randomized frames
    for (int i = 0; i < 12; i++) begin
      divisor = 8'($urandom_range(0, 14));
      send(8'($urandom), 1'($urandom_range(0, 1)));
      if (i == 11) host_if.in_valid = 1'b0;
    end
    host_if.in_valid = 1'b0;
    wait_idle();

    // Async reset during data bit 3, then a clean frame
    divisor = 8'd8;
    send(8'hA5, 1'b0);
    wait_cycle(last_start + 34);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    mon_en = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_tx", 32'(tx), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_div_wr_ok", 32'(div_wr_ok), 32'd0);
    chk("async_rst_in_ready", 32'(host_if.in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    in_frame = 1'b0;
    free_cycle = 0;
    mon_en = 1'b1;
    @(negedge clk);
    send(8'h3C, 1'b0);
    wait_idle();
    chk("queue_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
